// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive paths.
package uart_pkg;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable baud down-counter; tick_o marks the last clock of a bit period.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // A load wins over counting so each bit period starts from a fresh value.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with CTS flow control: start, 8 data bits LSB first, 1 or 2 stops.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 specman_hclk,
    input  logic                 hresetn,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 stop2,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 cts_n,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_en,
    input  logic                 parity_odd,
`endif
    output logic                 txd,
    output logic                 busy
);

    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_tx_state_e        state_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DIV_W-1:0]      baud_q;
    logic                  stop2_q;
    logic                  stop_cnt_q;
    logic                  txd_q;
    logic                  busy_q;
`ifdef UART_TX_PARITY_EN
    logic                  par_en_q;
    logic                  par_bit_q;
`endif

    logic                  accept;
    logic                  tick;
    logic                  baud_load;
    logic [DIV_W-1:0]      baud_load_val;

    assign tx_ready = (state_q == IDLE) & ~cts_n & hresetn;
    assign accept   = tx_valid & tx_ready;

    // Reload on acceptance and at every bit boundary; the frame uses the captured divisor.
    assign baud_load     = accept | (busy_q & tick);
    assign baud_load_val = (state_q == IDLE) ? baud_div : baud_q;

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .clk_i      (specman_hclk),
        .rst_ni     (hresetn),
        .load_i     (baud_load),
        .load_val_i (baud_load_val),
        .en_i       (busy_q),
        .tick_o     (tick)
    );

    always_ff @(posedge specman_hclk) begin
        if (!hresetn) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            baud_q     <= '0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            txd_q      <= UART_IDLE_LEVEL;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= START;
                        shift_q    <= tx_data;
                        idx_q      <= '0;
                        baud_q     <= baud_div;
                        stop2_q    <= stop2;
                        stop_cnt_q <= 1'b0;
                        txd_q      <= UART_START_LEVEL;
                        busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        par_en_q   <= parity_en;
                        par_bit_q  <= parity_odd ? ~(^tx_data) : ^tx_data;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state_q <= PARITY;
                                txd_q   <= par_bit_q;
                            end else begin
                                state_q <= STOP;
                                txd_q   <= UART_IDLE_LEVEL;
                            end
`else
                            state_q <= STOP;
                            txd_q   <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            txd_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state_q <= STOP;
                        txd_q   <= UART_IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    // With two stop bits the first tick only marks the end of the first period.
                    if (tick) begin
                        if (stop2_q && !stop_cnt_q) begin
                            stop_cnt_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= UART_IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes queue expected frames, a monitor checks txd bit by bit.
// Parity cases are compiled in when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        int         baud;
        bit         stop2;
        bit         parEn;
        bit         parOdd;
    } frame_t;

    logic        specman_hclk;
    logic        hresetn;
    logic [15:0] baud_div;
    logic        stop2;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cts_n;
`ifdef UART_TX_PARITY_EN
    logic        parity_en;
    logic        parity_odd;
`endif
    logic        txd;
    logic        busy;

    int     vectors     = 0;
    int     miscompares = 0;
    int     cycleCount  = 0;
    int     frameNum    = 0;
    bit     monitorIdle = 1'b1;
    frame_t expQ[$];
    int     startCycles[$];

    uart_tx #(
        .DIV_W     (16),
        .DATA_BITS (8)
    ) dut (
        .specman_hclk (specman_hclk),
        .hresetn      (hresetn),
        .baud_div     (baud_div),
        .stop2        (stop2),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .cts_n        (cts_n),
`ifdef UART_TX_PARITY_EN
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
`endif
        .txd          (txd),
        .busy         (busy)
    );

    initial specman_hclk = 1'b0;
    always #5 specman_hclk = ~specman_hclk;

    always @(posedge specman_hclk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, observed, expected, cycleCount);
        end
    endtask

    // Drives one byte and holds tx_valid until accepted; the expected frame is queued at acceptance.
    task automatic applyStimulus(input logic [7:0] data, input int baud, input bit s2,
                                 input bit pEn, input bit pOdd, input bit holdValid,
                                 output int waited);
        frame_t f;
        tx_data  = data;
        baud_div = 16'(baud);
        stop2    = s2;
`ifdef UART_TX_PARITY_EN
        parity_en  = pEn;
        parity_odd = pOdd;
`endif
        tx_valid = 1'b1;
        waited   = 0;
        @(negedge specman_hclk);
        while (tx_ready !== 1'b1 && waited < 2000) begin
            waited++;
            @(negedge specman_hclk);
        end
        if (tx_ready !== 1'b1) begin
            checkOutput("acceptTimeout", {31'd0, tx_ready}, 32'd1);
            tx_valid = 1'b0;
        end else begin
            f = '{data, baud, s2, pEn, pOdd};
            expQ.push_back(f);
            @(posedge specman_hclk);
            #1;
            if (!holdValid) tx_valid = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int guard = 0;
        @(negedge specman_hclk);
        while (!(monitorIdle && expQ.size() == 0 && busy === 1'b0) && guard < 3000) begin
            guard++;
            @(negedge specman_hclk);
        end
        if (guard >= 3000) checkOutput("waitIdleTimeout", 32'd0, 32'd1);
        @(posedge specman_hclk);
        #1;
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bit(s); each bit must hold for its whole period.
    task automatic runFrame(input frame_t f);
        logic expBits [12];
        logic observed;
        int   nBits;
        int   frameLen;
        int   seenLen = 0;
        int   guard   = 0;
        int   ones;
        bit   aborted = 1'b0;
        bit   readyOk = 1'b1;
        expBits[0] = 1'b0;
        for (int i = 0; i < 8; i++) expBits[1 + i] = f.data[i];
        nBits = 9;
        if (f.parEn) begin
            ones = $countones(f.data);
            expBits[nBits] = (ones % 2 == 1) ? !f.parOdd : f.parOdd;
            nBits++;
        end
        expBits[nBits] = 1'b1;
        nBits++;
        if (f.stop2) begin
            expBits[nBits] = 1'b1;
            nBits++;
        end
        frameLen = nBits * (f.baud + 1);
        for (int b = 0; b < nBits && !aborted; b++) begin
            observed = expBits[b];
            for (int c = 0; c <= f.baud; c++) begin
                if (b != 0 || c != 0) @(negedge specman_hclk);
                if (hresetn !== 1'b1) begin
                    aborted = 1'b1;
                    break;
                end
                if (txd !== expBits[b]) observed = txd;
                if (busy === 1'b1) seenLen++;
                if (tx_ready !== 1'b0) readyOk = 1'b0;
            end
            if (!aborted) checkOutput($sformatf("frame%0d_bit%0d", frameNum, b), {31'd0, observed}, {31'd0, expBits[b]});
        end
        if (!aborted) begin
            @(negedge specman_hclk);
            while (busy === 1'b1 && guard < 1000 && hresetn === 1'b1) begin
                seenLen++;
                guard++;
                @(negedge specman_hclk);
            end
            checkOutput($sformatf("frame%0d_busyLen", frameNum), seenLen, frameLen);
            checkOutput($sformatf("frame%0d_readyLow", frameNum), {31'd0, readyOk}, 32'd1);
            checkOutput($sformatf("frame%0d_idleAfter", frameNum), {31'd0, txd}, 32'd1);
        end
        frameNum++;
    endtask

    initial begin : monitorProc
        frame_t f;
        int guard;
        forever begin
            @(negedge specman_hclk);
            if (hresetn === 1'b1 && busy === 1'b1) begin
                monitorIdle = 1'b0;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedFrame", 32'd1, 32'd0);
                    guard = 0;
                    while (busy === 1'b1 && guard < 1000) begin
                        guard++;
                        @(negedge specman_hclk);
                    end
                end else begin
                    f = expQ.pop_front();
                    startCycles.push_back(cycleCount);
                    runFrame(f);
                end
                monitorIdle = 1'b1;
            end
        end
    end

    initial begin : mainProc
        int waited;
        int n;
        hresetn  = 1'b0;
        baud_div = '0;
        stop2    = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        cts_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_en  = 1'b0;
        parity_odd = 1'b0;
`endif
        repeat (3) @(posedge specman_hclk);
        @(negedge specman_hclk);
        checkOutput("resetTxd", {31'd0, txd}, 32'd1);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetReady", {31'd0, tx_ready}, 32'd0);
        @(posedge specman_hclk);
        #1;
        hresetn = 1'b1;
        @(negedge specman_hclk);
        checkOutput("readyAfterReset", {31'd0, tx_ready}, 32'd1);
        @(posedge specman_hclk);
        #1;

        $display("[TB] single frame 0x55, 4 clocks per bit");
        applyStimulus(8'h55, 3, 1'b0, 1'b0, 1'b0, 1'b0, waited);
        waitIdle();

        $display("[TB] back-to-back 0xA3, 0x0F, 1 clock per bit, two stops");
        n = startCycles.size();
        applyStimulus(8'hA3, 0, 1'b1, 1'b0, 1'b0, 1'b1, waited);
        applyStimulus(8'h0F, 0, 1'b1, 1'b0, 1'b0, 1'b0, waited);
        waitIdle();
        if (startCycles.size() >= n + 2)
            checkOutput("b2bSpacing", startCycles[n + 1] - startCycles[n], 32'd12);
        else
            checkOutput("b2bFrames", startCycles.size() - n, 32'd2);

        $display("[TB] cts_n held high with tx_valid");
        cts_n    = 1'b1;
        tx_data  = 8'hC3;
        baud_div = 16'd1;
        tx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge specman_hclk);
            checkOutput("ctsBlockReady", {31'd0, tx_ready}, 32'd0);
            checkOutput("ctsBlockTxd", {31'd0, txd}, 32'd1);
        end
        @(posedge specman_hclk);
        #1;
        cts_n = 1'b0;
        applyStimulus(8'hC3, 1, 1'b0, 1'b0, 1'b0, 1'b0, waited);
        checkOutput("ctsAcceptWait", waited, 32'd0);
        checkOutput("ctsStartBit", {31'd0, txd}, 32'd0);
        checkOutput("ctsStartBusy", {31'd0, busy}, 32'd1);
        waitIdle();

        $display("[TB] cts_n raised mid-frame");
        applyStimulus(8'h96, 2, 1'b0, 1'b0, 1'b0, 1'b0, waited);
        repeat (12) @(posedge specman_hclk);
        #1;
        cts_n = 1'b1;
        waitIdle();
        for (int i = 0; i < 4; i++) begin
            @(negedge specman_hclk);
            checkOutput("ctsHeldReady", {31'd0, tx_ready}, 32'd0);
        end
        @(posedge specman_hclk);
        #1;
        cts_n = 1'b0;
        @(negedge specman_hclk);
        checkOutput("ctsReleasedReady", {31'd0, tx_ready}, 32'd1);
        @(posedge specman_hclk);
        #1;

        $display("[TB] reset during data bit 4");
        applyStimulus(8'h3C, 1, 1'b0, 1'b0, 1'b0, 1'b0, waited);
        repeat (10) @(posedge specman_hclk);
        #1;
        hresetn = 1'b0;
        @(negedge specman_hclk);
        @(negedge specman_hclk);
        checkOutput("midResetTxd", {31'd0, txd}, 32'd1);
        checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
        checkOutput("midResetReady", {31'd0, tx_ready}, 32'd0);
        @(posedge specman_hclk);
        #1;
        hresetn = 1'b1;
        applyStimulus(8'h81, 2, 1'b0, 1'b0, 1'b0, 1'b0, waited);
        waitIdle();

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity frames for 0x07");
        applyStimulus(8'h07, 1, 1'b0, 1'b1, 1'b0, 1'b0, waited);
        waitIdle();
        applyStimulus(8'h07, 1, 1'b0, 1'b1, 1'b1, 1'b0, waited);
        waitIdle();
        applyStimulus(8'h07, 1, 1'b1, 1'b0, 1'b1, 1'b0, waited);
        waitIdle();
`endif

        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
